alu_arbiter: RTL and testbench

//  Shares the single combinational ALU (cmd 0-15: add, sub, logic, shifts, compares) between NREQ requesters.

---
 rtl/alu_ctrl_pkg.sv | 32 +++
 rtl/alu_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/alu_arbiter.sv | 136 +++++++++++++
 tb/tb_alu_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU arbiter slice.
// No logic; widths, FSM state encoding and ALU opcode values.
// Opcode constants let clients and benches name operations symbolically.
package alu_ctrl_pkg;

    localparam int DW    = 32;
    localparam int CMD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [CMD_W-1:0] ALU_ADD = 4'd0;
    localparam logic [CMD_W-1:0] ALU_SUB = 4'd1;
    localparam logic [CMD_W-1:0] ALU_AND = 4'd2;
    localparam logic [CMD_W-1:0] ALU_OR  = 4'd3;
    localparam logic [CMD_W-1:0] ALU_NOT = 4'd4;
    localparam logic [CMD_W-1:0] ALU_NOR = 4'd5;
    localparam logic [CMD_W-1:0] ALU_XOR = 4'd6;
    localparam logic [CMD_W-1:0] ALU_NEG = 4'd7;
    localparam logic [CMD_W-1:0] ALU_SLL = 4'd8;
    localparam logic [CMD_W-1:0] ALU_SRL = 4'd9;
    localparam logic [CMD_W-1:0] ALU_SRA = 4'd10;
    localparam logic [CMD_W-1:0] ALU_GE  = 4'd11;
    localparam logic [CMD_W-1:0] ALU_LE  = 4'd12;
    localparam logic [CMD_W-1:0] ALU_GT  = 4'd13;
    localparam logic [CMD_W-1:0] ALU_LT  = 4'd14;
    localparam logic [CMD_W-1:0] ALU_EQ  = 4'd15;

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU-side and response signals around the arbiter.
// Pure wiring, no latency.
// slave = arbiter side; master = requesters, ALU and response consumer.
interface alu_arbiter_if
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ = 2
);

    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DW-1:0]    req_src;
    logic [NREQ*DW-1:0]    req_dest;
    logic [NREQ*CMD_W-1:0] req_cmd;
    logic [NREQ-1:0]       req_ready;

    logic [DW-1:0]         alu_src;
    logic [DW-1:0]         alu_dest;
    logic [CMD_W-1:0]      alu_cmd;
    logic [DW-1:0]         alu_res;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [DW-1:0]         rsp_res;

    modport slave (
        input  req_valid, req_src, req_dest, req_cmd, alu_res, rsp_ready,
        output req_ready, alu_src, alu_dest, alu_cmd, rsp_valid, rsp_id, rsp_res
    );

    modport master (
        output req_valid, req_src, req_dest, req_cmd, alu_res, rsp_ready,
        input  req_ready, alu_src, alu_dest, alu_cmd, rsp_valid, rsp_id, rsp_res
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request scanning upward from last_grant+1, wrapping.
// Combinational, zero latency.
// No backpressure; caller decides whether the grant is taken.
module rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_last_grant,
    output logic [NREQ-1:0] o_grant_oh,
    output logic [IDW-1:0]  o_grant_idx,
    output logic            o_grant_vld
);

    logic [NREQ-1:0] w_upper;
    logic [NREQ-1:0] w_masked;
    logic [NREQ-1:0] w_pick;

    // Requesters strictly above the last winner get first chance this round.
    for (genvar g = 0; g < NREQ; g++) begin : g_mask
        assign w_upper[g] = (IDW'(g) > i_last_grant);
    end

    assign w_masked = i_req & w_upper;
    // Nobody above the last winner: wrap around and take the lowest requester.
    assign w_pick   = (|w_masked) ? w_masked : i_req;

    // Isolate the lowest set bit of the candidate vector.
    assign o_grant_oh  = w_pick & (~w_pick + NREQ'(1));
    assign o_grant_vld = |i_req;

    // One-hot to binary: index bit b is the OR of grant lines whose index has bit b set.
    for (genvar b = 0; b < IDW; b++) begin : g_enc
        logic [NREQ-1:0] w_sel;
        for (genvar g = 0; g < NREQ; g++) begin : g_bit
            assign w_sel[g] = o_grant_oh[g] && (((g >> b) % 2) == 1);
        end
        assign o_grant_idx[b] = |w_sel;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one combinational ALU among NREQ requesters, round-robin.
// Accept at T -> rsp_valid at T+2; next accept no earlier than T+3.
// Holds the response indefinitely while rsp_ready is low; no accepts meanwhile.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);

    localparam int IDW = $clog2(NREQ);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [IDW-1:0]   r_last_grant;
    logic [IDW-1:0]   w_grant_idx;
    logic [NREQ-1:0]  w_grant_oh;
    logic             w_grant_vld;

    logic [DW-1:0]    r_alu_src;
    logic [DW-1:0]    r_alu_dest;
    logic [CMD_W-1:0] r_alu_cmd;
    logic [IDW-1:0]   r_rsp_id;
    logic [DW-1:0]    r_rsp_res;
    logic             r_rsp_vld;

    logic             w_accept;
    logic             w_rsp_hs;

    logic [DW-1:0]    w_src_arr  [NREQ];
    logic [DW-1:0]    w_dest_arr [NREQ];
    logic [CMD_W-1:0] w_cmd_arr  [NREQ];
    logic [DW-1:0]    w_sel_src;
    logic [DW-1:0]    w_sel_dest;
    logic [CMD_W-1:0] w_sel_cmd;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .i_req        (bus.req_valid),
        .i_last_grant (r_last_grant),
        .o_grant_oh   (w_grant_oh),
        .o_grant_idx  (w_grant_idx),
        .o_grant_vld  (w_grant_vld)
    );

    // Unpack the flat per-requester buses so the winner can be picked by index.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_src_arr[g]  = bus.req_src[g*DW +: DW];
        assign w_dest_arr[g] = bus.req_dest[g*DW +: DW];
        assign w_cmd_arr[g]  = bus.req_cmd[g*CMD_W +: CMD_W];
    end

    assign w_sel_src  = w_src_arr[w_grant_idx];
    assign w_sel_dest = w_dest_arr[w_grant_idx];
    assign w_sel_cmd  = w_cmd_arr[w_grant_idx];

    // Next-state and handshake decode: accept only when idle, release only on response handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_vld) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant is shown only while idle and out of reset, so it is never visible unless actually taken.
    assign bus.req_ready = (w_accept && !rst) ? w_grant_oh : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture on accept, result capture leaving EXEC, response clear on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_src    <= '0;
            r_alu_dest   <= '0;
            r_alu_cmd    <= '0;
            r_rsp_id     <= '0;
            r_rsp_res    <= '0;
            r_rsp_vld    <= 1'b0;
            r_last_grant <= IDW'(NREQ - 1);
        end else begin
            if (w_accept) begin
                r_alu_src    <= w_sel_src;
                r_alu_dest   <= w_sel_dest;
                r_alu_cmd    <= w_sel_cmd;
                r_rsp_id     <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end
            if (r_state == ST_EXEC) begin
                r_rsp_res <= bus.alu_res;
                r_rsp_vld <= 1'b1;
            end
            if (w_rsp_hs) begin
                r_rsp_vld <= 1'b0;
            end
        end
    end

    assign bus.alu_src   = r_alu_src;
    assign bus.alu_dest  = r_alu_dest;
    assign bus.alu_cmd   = r_alu_cmd;
    assign bus.rsp_valid = r_rsp_vld;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_res   = r_rsp_res;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic against a reference model.
// The ALU itself lives here as a behavioural function driving alu_res.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_alu_arbiter;
    import alu_ctrl_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = $clog2(NREQ);

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_arbiter_if #(.NREQ(NREQ)) bus ();

    alu_arbiter #(.NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: binary ops compute dest OP src; shifts move src by dest[3:0].
    function automatic logic [DW-1:0] alu_ref(input logic [CMD_W-1:0] cmd,
                                              input logic [DW-1:0] s, input logic [DW-1:0] d);
        case (cmd)
            ALU_ADD: return d + s;
            ALU_SUB: return d - s;
            ALU_AND: return d & s;
            ALU_OR:  return d | s;
            ALU_NOT: return ~s;
            ALU_NOR: return ~(d | s);
            ALU_XOR: return d ^ s;
            ALU_NEG: return -s;
            ALU_SLL: return s << d[3:0];
            ALU_SRL: return s >> d[3:0];
            ALU_SRA: return DW'($signed(s) >>> d[3:0]);
            ALU_GE:  return DW'(d >= s);
            ALU_LE:  return DW'(d <= s);
            ALU_GT:  return DW'(d > s);
            ALU_LT:  return DW'(d < s);
            default: return DW'(d == s);
        endcase
    endfunction

    assign bus.alu_res = alu_ref(bus.alu_cmd, bus.alu_src, bus.alu_dest);

    // Round-robin rule: first valid requester after the last winner, wrapping; -1 if none.
    function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic randomize_operands;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_src[i*DW +: DW]        = $urandom;
            bus.req_dest[i*DW +: DW]       = $urandom;
            bus.req_cmd[i*CMD_W +: CMD_W]  = CMD_W'($urandom_range(0, 15));
        end
    endtask

    task automatic do_reset;
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.req_valid = '1;
        randomize_operands();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.req_ready !== '0)  begin errors++; $display("FAIL reset_req_ready got %b want 0", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_id !== '0)     begin errors++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
        checks++; if (bus.rsp_res !== '0)    begin errors++; $display("FAIL reset_rsp_res got %h want 0", bus.rsp_res); end
        checks++; if (bus.alu_src !== '0 || bus.alu_dest !== '0 || bus.alu_cmd !== '0) begin
            errors++; $display("FAIL reset_alu got %h %h %h want 0 0 0", bus.alu_src, bus.alu_dest, bus.alu_cmd);
        end
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.req_valid = '0;
    endtask

    task automatic test_directed_ops;
        int               t_idx [4] = '{0, 1, 0, 0};
        logic [DW-1:0]    t_src [4] = '{32'd5, 32'd3, 32'd1, 32'hA5};
        logic [DW-1:0]    t_dst [4] = '{32'd3, 32'd10, 32'h1F, 32'hA5};
        logic [CMD_W-1:0] t_cmd [4] = '{ALU_ADD, ALU_SUB, ALU_SLL, ALU_EQ};
        logic [DW-1:0]    t_exp [4] = '{32'd8, 32'd7, 32'h0000_8000, 32'd1};
        logic [NREQ-1:0]  exp_oh;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            randomize_operands();
            bus.rsp_ready = 1'b1;
            bus.req_valid = '0;
            bus.req_valid[t_idx[k]] = 1'b1;
            bus.req_src[t_idx[k]*DW +: DW]       = t_src[k];
            bus.req_dest[t_idx[k]*DW +: DW]      = t_dst[k];
            bus.req_cmd[t_idx[k]*CMD_W +: CMD_W] = t_cmd[k];
            exp_oh = '0;
            exp_oh[t_idx[k]] = 1'b1;
            @(negedge clk);
            checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL op%0d_grant got %b want %b", k, bus.req_ready, exp_oh); end
            // Operands may change freely once granted.
            @(posedge clk); #1;
            bus.req_valid = '0;
            randomize_operands();
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== '0) begin
                errors++; $display("FAIL op%0d_exec rsp_valid %b req_ready %b want 0 0", k, bus.rsp_valid, bus.req_ready);
            end
            @(negedge clk);
            checks++; if (bus.rsp_valid !== 1'b1)          begin errors++; $display("FAIL op%0d_rsp_valid got %b want 1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_res !== t_exp[k])        begin errors++; $display("FAIL op%0d_rsp_res got %h want %h", k, bus.rsp_res, t_exp[k]); end
            checks++; if (bus.rsp_id !== IDW'(t_idx[k]))   begin errors++; $display("FAIL op%0d_rsp_id got %0d want %0d", k, bus.rsp_id, t_idx[k]); end
            checks++; if (bus.alu_cmd !== t_cmd[k])        begin errors++; $display("FAIL op%0d_alu_cmd got %0d want %0d", k, bus.alu_cmd, t_cmd[k]); end
        end
    endtask

    task automatic test_fairness;
        int              ngrant;
        logic [NREQ-1:0] exp_oh;
        do_reset();
        randomize_operands();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        ngrant = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.req_ready !== '0) begin
                exp_oh = '0;
                exp_oh[ngrant % NREQ] = 1'b1;
                checks++; if (c != 3 * ngrant) begin errors++; $display("FAIL fair_cycle grant %0d at cycle %0d want %0d", ngrant, c, 3 * ngrant); end
                checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL fair_order grant %0d got %b want %b", ngrant, bus.req_ready, exp_oh); end
                ngrant++;
            end
        end
        checks++; if (ngrant != 4) begin errors++; $display("FAIL fair_count got %0d want 4", ngrant); end
        bus.req_valid = '0;
    endtask

    task automatic test_backpressure;
        logic [DW-1:0] exp_res;
        int            wait_n;
        do_reset();
        randomize_operands();
        bus.req_valid = '1;
        bus.rsp_ready = 1'b0;
        exp_res = alu_ref(bus.req_cmd[0 +: CMD_W], bus.req_src[0 +: DW], bus.req_dest[0 +: DW]);
        @(negedge clk);
        checks++; if (bus.req_ready !== NREQ'(1)) begin errors++; $display("FAIL bp_grant got %b want 01", bus.req_ready); end
        wait_n = 0;
        while (bus.rsp_valid !== 1'b1 && wait_n < 6) begin
            @(negedge clk);
            wait_n++;
        end
        checks++; if (wait_n != 2) begin errors++; $display("FAIL bp_latency got %0d cycles want 2", wait_n); end
        for (int c = 0; c < 5; c++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== '0 || bus.rsp_res !== exp_res || bus.req_ready !== '0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got v=%b id=%0d res=%h rdy=%b want v=1 id=0 res=%h rdy=0",
                         c, bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.req_ready, exp_res);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_before_hs got %b want 1", bus.rsp_valid); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== NREQ'(2)) begin
            errors++; $display("FAIL bp_resume got v=%b rdy=%b want v=0 rdy=10", bus.rsp_valid, bus.req_ready);
        end
        bus.req_valid = '0;
    endtask

    task automatic test_reset_exec;
        do_reset();
        bus.req_valid = NREQ'(1);
        bus.req_src[0 +: DW]      = 32'd5;
        bus.req_dest[0 +: DW]     = 32'd3;
        bus.req_cmd[0 +: CMD_W]   = ALU_SUB;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.req_ready !== NREQ'(1)) begin errors++; $display("FAIL rx_grant got %b want 01", bus.req_ready); end
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.req_valid = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.alu_src !== '0 || bus.alu_dest !== '0 || bus.alu_cmd !== '0) begin
            errors++; $display("FAIL rx_alu_cleared got %h %h %h want 0 0 0", bus.alu_src, bus.alu_dest, bus.alu_cmd);
        end
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rx_no_rsp cycle %0d got %b want 0", c, bus.rsp_valid); end
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.req_valid = '1;
        @(negedge clk);
        checks++; if (bus.req_ready !== NREQ'(1)) begin errors++; $display("FAIL rx_next_grant got %b want 01", bus.req_ready); end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random;
        bit              m_busy;
        int              m_cnt;
        int              m_last;
        int              m_id;
        int              g;
        logic [DW-1:0]   m_res;
        logic [NREQ-1:0] exp_oh;
        do_reset();
        m_busy = 1'b0;
        m_cnt  = 0;
        m_last = NREQ - 1;
        m_id   = 0;
        m_res  = '0;
        for (int c = 0; c < 400; c++) begin
            if (c != 0) begin
                @(posedge clk); #1;
            end
            randomize_operands();
            bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (!m_busy) begin
                g = rr_pick(bus.req_valid, m_last);
                exp_oh = '0;
                if (g >= 0) exp_oh[g] = 1'b1;
                checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL rnd_grant cycle %0d got %b want %b", c, bus.req_ready, exp_oh); end
                checks++; if (bus.rsp_valid !== 1'b0)   begin errors++; $display("FAIL rnd_idle_valid cycle %0d got %b want 0", c, bus.rsp_valid); end
                if (g >= 0) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                    m_last = g;
                    m_id   = g;
                    m_res  = alu_ref(bus.req_cmd[g*CMD_W +: CMD_W], bus.req_src[g*DW +: DW], bus.req_dest[g*DW +: DW]);
                end
            end else begin
                m_cnt++;
                checks++; if (bus.req_ready !== '0) begin errors++; $display("FAIL rnd_busy_ready cycle %0d got %b want 0", c, bus.req_ready); end
                if (m_cnt == 1) begin
                    checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_exec_valid cycle %0d got %b want 0", c, bus.rsp_valid); end
                end else begin
                    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== IDW'(m_id) || bus.rsp_res !== m_res) begin
                        errors++;
                        $display("FAIL rnd_rsp cycle %0d got v=%b id=%0d res=%h want v=1 id=%0d res=%h",
                                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_res, m_id, m_res);
                    end
                    if (bus.rsp_ready) m_busy = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_src   = '0;
        bus.req_dest  = '0;
        bus.req_cmd   = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_directed_ops();
        test_fairness();
        test_backpressure();
        test_reset_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
